// File: rtl/bist_scheduler.sv
// bist_scheduler: shares one BIST controller among N_CORES cores.
// Round-robin grant, one-cycle start pulse, signature check against the
// per-core golden value, sticky watchdog error. All outputs are registered.
module bist_scheduler #(
   parameter int N_CORES = 4,
   parameter int SIG_W   = 16,
   parameter int TIMEOUT = 1023,
   localparam int CORE_W = $clog2(N_CORES),
   localparam int TMR_W  = $clog2(TIMEOUT + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CORES-1:0]       req,
   input  logic [N_CORES*SIG_W-1:0] gold_sig,
   input  logic                     bist_end,
   input  logic [SIG_W-1:0]         misr_sig,
   output logic                     bist_start,
   output logic [CORE_W-1:0]        bist_sel,
   output logic [N_CORES-1:0]       grant,
   output logic [N_CORES-1:0]       done,
   output logic [N_CORES-1:0]       pass,
   output logic                     busy,
   output logic                     timeout_err
);

   typedef enum logic [1:0] {IDLE, START, WAIT, CHECK} state_t;

   state_t            state;
   logic [CORE_W-1:0] last;
   logic [CORE_W-1:0] pick;
   logic [TMR_W-1:0]  timer;
   logic [SIG_W-1:0]  captured;

   // Round-robin pick: first requesting core after the last one served.
   // Scanning from the far end lets the nearest candidate overwrite the rest.
   always_comb begin
      pick = last;
      for (int unsigned i = N_CORES; i >= 1; i--) begin
         if (req[CORE_W'((32'(last) + i) % N_CORES)])
            pick = CORE_W'((32'(last) + i) % N_CORES);
      end
   end

   // Scheduler FSM; bist_sel doubles as the latched core index for the test.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last        <= CORE_W'(N_CORES - 1);
         timer       <= '0;
         captured    <= '0;
         bist_start  <= 1'b0;
         bist_sel    <= '0;
         grant       <= '0;
         done        <= '0;
         pass        <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         done <= '0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  bist_sel <= pick;
                  grant    <= N_CORES'(1) << pick;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               bist_start <= 1'b1;
               timer      <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               bist_start <= 1'b0;
               if (bist_end) begin
                  captured <= misr_sig;
                  state    <= CHECK;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  pass[bist_sel] <= 1'b0;
                  done[bist_sel] <= 1'b1;
                  timeout_err    <= 1'b1;
                  grant          <= '0;
                  busy           <= 1'b0;
                  last           <= bist_sel;
                  state          <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CHECK: begin
               pass[bist_sel] <= (captured == gold_sig[bist_sel*SIG_W +: SIG_W]);
               done[bist_sel] <= 1'b1;
               grant          <= '0;
               busy           <= 1'b0;
               last           <= bist_sel;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_scheduler.sv
// Testbench for bist_scheduler: directed vector table, hand sequences for
// round-robin, reset and stray-end corners, then randomized tests. A
// transaction-level monitor predicts every output cycle by cycle.
module tb_bist_scheduler;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int TO = 20;
   localparam int CW = $clog2(N);

   logic           clk      = 1'b0;
   logic           reset    = 1'b0;
   logic [N-1:0]   req      = '0;
   logic [N*W-1:0] gold     = '0;
   logic           bist_end = 1'b0;
   logic [W-1:0]   misr     = '0;
   logic           bist_start;
   logic [CW-1:0]  bist_sel;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic [N-1:0]   pass;
   logic           busy;
   logic           timeout_err;

   int total   = 0;
   int bad     = 0;
   int rst_cnt = 0;
   bit mon_on  = 1'b0;

   bist_scheduler #(.N_CORES(N), .SIG_W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .gold_sig(gold),
      .bist_end(bist_end), .misr_sig(misr), .bist_start(bist_start),
      .bist_sel(bist_sel), .grant(grant), .done(done), .pass(pass),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge reset) rst_cnt = rst_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: actual=none required=event within bound", nm);
   endtask

   function automatic logic [N-1:0] onehot(input int unsigned c);
      return N'(1) << c;
   endfunction

   function automatic logic [W-1:0] gold_of(input int unsigned c);
      return W'(gold >> (c * W));
   endfunction

   // Round-robin rule: first set bit after 'last', wrapping around.
   function automatic int unsigned rr(input int unsigned lst, input logic [N-1:0] r);
      for (int unsigned i = 1; i <= N; i++)
         if (((r >> ((lst + i) % N)) & N'(1)) != '0) return (lst + i) % N;
      return lst;
   endfunction

   // ---------------- reference monitor ----------------
   bit           m_in = 1'b0, m_to = 1'b0, m_ok = 1'b0, m_ended = 1'b0;
   int           m_g = 0, m_fin = 0, m_rst_seen = 0;
   int unsigned  m_last = N - 1, m_cur = 0;
   logic [N-1:0] m_pass = '0, m_req = '0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (reset || rst_cnt != m_rst_seen) begin
            m_rst_seen = rst_cnt;
            m_in = 1'b0; m_last = N - 1; m_pass = '0; m_to = 1'b0;
            chk("rst_grant", 32'(grant), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_start", 32'(bist_start), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_pass", 32'(pass), 0);
            chk("rst_tmo", 32'(timeout_err), 0);
            chk("rst_sel", 32'(bist_sel), 0);
         end else if (!m_in) begin
            if (m_req == '0) begin
               chk("idle_grant", 32'(grant), 0);
               chk("idle_busy", 32'(busy), 0);
            end else begin
               m_cur = rr(m_last, m_req);
               m_in = 1'b1; m_g = 0; m_fin = TO + 1; m_ended = 1'b0;
               chk("arb_grant", 32'(grant), 32'(onehot(m_cur)));
               chk("arb_sel", 32'(bist_sel), m_cur);
               chk("arb_busy", 32'(busy), 1);
            end
            chk("idle_start", 32'(bist_start), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_pass", 32'(pass), 32'(m_pass));
            chk("idle_tmo", 32'(timeout_err), 32'(m_to));
         end else begin
            m_g++;
            chk("start_pulse", 32'(bist_start), (m_g == 1) ? 1 : 0);
            if (m_g == m_fin) begin
               if (m_ended)
                  m_pass = (m_pass & ~onehot(m_cur)) | (m_ok ? onehot(m_cur) : N'(0));
               else begin
                  m_pass = m_pass & ~onehot(m_cur);
                  m_to = 1'b1;
               end
               chk("fin_done", 32'(done), 32'(onehot(m_cur)));
               chk("fin_grant", 32'(grant), 0);
               chk("fin_busy", 32'(busy), 0);
               chk("fin_pass", 32'(pass), 32'(m_pass));
               chk("fin_tmo", 32'(timeout_err), 32'(m_to));
               m_in = 1'b0;
               m_last = m_cur;
            end else begin
               chk("run_grant", 32'(grant), 32'(onehot(m_cur)));
               chk("run_busy", 32'(busy), 1);
               chk("run_sel", 32'(bist_sel), m_cur);
               chk("run_done", 32'(done), 0);
               chk("run_pass", 32'(pass), 32'(m_pass));
               chk("run_tmo", 32'(timeout_err), 32'(m_to));
               if (!m_ended && bist_end && m_g <= TO) begin
                  m_ended = 1'b1;
                  m_fin = m_g + 2;
                  m_ok = (misr == gold_of(m_cur));
               end
            end
         end
         m_req = req;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (grant != '0) begin ok = 1'b1; break; end
      end
      if (!ok) bound_fail("wait_grant");
   endtask

   task automatic wait_done(output logic [N-1:0] d, output bit ok);
      ok = 1'b0;
      d = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done != '0) begin ok = 1'b1; d = done; break; end
      end
      if (!ok) bound_fail("wait_done");
   endtask

   // Behavioural BIST controller: bist_end is sampled by the scheduler
   // 'delay' cycles after the edge that raised bist_start (0 = never ends).
   task automatic serve(input int delay, input logic [W-1:0] flip, input logic [N-1:0] newreq);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bist_start) begin seen = 1'b1; break; end
      end
      if (!seen) begin bound_fail("wait_start"); return; end
      req = newreq;
      if (delay != 0) begin
         repeat (delay - 1) begin @(posedge clk); #1; end
         bist_end = 1'b1;
         misr = gold_of(m_cur) ^ flip;
         @(posedge clk); #1;
         bist_end = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("async_grant", 32'(grant), 0);
      chk("async_busy", 32'(busy), 0);
      chk("async_start", 32'(bist_start), 0);
      chk("async_tmo", 32'(timeout_err), 0);
      #2 reset = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0] req;
      int           delay;
      logic [W-1:0] flip;
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_pass;
      bit           exp_to;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [N-1:0] d;
      bit ok;
      logic [W-1:0] fl;

      vecs[0] = '{req: 4'b0001, delay: 10, flip: 16'h0000, exp_grant: 4'b0001, exp_pass: 4'b0001, exp_to: 1'b0};
      vecs[1] = '{req: 4'b0010, delay: 5,  flip: 16'h0001, exp_grant: 4'b0010, exp_pass: 4'b0001, exp_to: 1'b0};
      vecs[2] = '{req: 4'b0100, delay: 0,  flip: 16'h0000, exp_grant: 4'b0100, exp_pass: 4'b0001, exp_to: 1'b1};
      vecs[3] = '{req: 4'b1000, delay: 20, flip: 16'h0000, exp_grant: 4'b1000, exp_pass: 4'b1001, exp_to: 1'b1};
      vecs[4] = '{req: 4'b0010, delay: 1,  flip: 16'h0000, exp_grant: 4'b0010, exp_pass: 4'b1011, exp_to: 1'b1};
      vecs[5] = '{req: 4'b0011, delay: 3,  flip: 16'h0001, exp_grant: 4'b0001, exp_pass: 4'b1010, exp_to: 1'b1};
      vecs[6] = '{req: 4'b1100, delay: 19, flip: 16'h0000, exp_grant: 4'b0100, exp_pass: 4'b1110, exp_to: 1'b1};
      vecs[7] = '{req: 4'b1001, delay: 2,  flip: 16'h8000, exp_grant: 4'b1000, exp_pass: 4'b0110, exp_to: 1'b1};

      gold = {16'hC3C3, 16'h0F0F, 16'h1234, 16'hA5A5};

      // reset state
      #13 reset = 1'b1;
      #1 mon_on = 1'b1;
      chk("reset_grant", 32'(grant), 0);
      chk("reset_start", 32'(bist_start), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_pass", 32'(pass), 0);
      chk("reset_tmo", 32'(timeout_err), 0);
      #12 reset = 1'b0;
      repeat (4) @(negedge clk);

      // directed vectors
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         req = vecs[i].req;
         wait_grant(ok);
         if (ok) begin
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            serve(vecs[i].delay, vecs[i].flip, '0);
            wait_done(d, ok);
            if (ok) begin
               chk($sformatf("vec%0d_done", i), 32'(d), 32'(vecs[i].exp_grant));
               chk($sformatf("vec%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
               chk($sformatf("vec%0d_tmo", i), 32'(timeout_err), 32'(vecs[i].exp_to));
            end
         end
      end

      // bist_end while idle is ignored
      @(posedge clk); #1;
      bist_end = 1'b1;
      misr = 16'hFFFF;
      @(posedge clk); #1;
      bist_end = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_done", 32'(done), 0);
      chk("stray_grant", 32'(grant), 0);
      chk("stray_pass", 32'(pass), 32'(4'b0110));

      // all cores requesting: rotation and single-cycle busy gap
      pulse_reset();
      @(posedge clk); #1;
      req = '1;
      wait_grant(ok);
      for (int i = 0; i < 5 && ok; i++) begin
         chk($sformatf("rot%0d_grant", i), 32'(grant), 32'(onehot(i % N)));
         serve(3, '0, (i < 4) ? {N{1'b1}} : {N{1'b0}});
         wait_done(d, ok);
         if (ok) begin
            chk($sformatf("rot%0d_done", i), 32'(d), 32'(onehot(i % N)));
            chk($sformatf("rot%0d_gap", i), 32'(busy), 0);
            @(negedge clk);
            chk($sformatf("rot%0d_busy_next", i), 32'(busy), (i < 4) ? 1 : 0);
         end
      end

      // reset in the middle of a test on core 1
      @(posedge clk); #1;
      req = 4'b0010;
      wait_grant(ok);
      chk("mid_grant", 32'(grant), 32'(4'b0010));
      serve(0, '0, '0);
      repeat (2) @(posedge clk);
      pulse_reset();
      @(posedge clk); #1;
      req = 4'b0011;
      wait_grant(ok);
      chk("post_rst_grant", 32'(grant), 32'(4'b0001));
      serve(2, '0, '0);
      wait_done(d, ok);
      chk("post_rst_done", 32'(d), 32'(4'b0001));
      chk("post_rst_pass", 32'(pass), 32'(4'b0001));
      chk("post_rst_tmo", 32'(timeout_err), 0);

      // randomized tests, checked by the monitor
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) gold[k*W +: W] = W'($urandom);
      for (int it = 0; it < 40; it++) begin
         @(posedge clk); #1;
         req = N'($urandom_range(1, (1 << N) - 1));
         fl = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 65535));
         serve(int'($urandom_range(0, TO)), fl, N'($urandom_range(0, (1 << N) - 1)));
         wait_done(d, ok);
      end
      req = '0;
      repeat (30) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
